// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format constants: bit positions of every field and the nop encoding.
package mips_pkg;

    localparam int OP_HI    = 31;
    localparam int OP_LO    = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int ADDR_HI  = 25;
    localparam int ADDR_LO  = 0;

    // sll $0,$0,0 -- the canonical MIPS nop
    localparam logic [31:0] NOP_WORD = 32'h0;

endpackage

// File: rtl/ir_fifo_mem.sv
// DEPTH x WIDTH prefetch storage: one synchronous write port, one asynchronous read port.
module ir_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // Contents are don't-care until written; the queue's Count guards every read.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ir_queue.sv
// MIPS instruction register with a DEPTH-entry prefetch queue in front of it.
// Define IR_QUEUE_FIELDS_EN to add decoded instruction-field outputs (requires WIDTH == 32).
module ir_queue
    import mips_pkg::*;
#(
    parameter int                WIDTH     = 32,
    parameter int                DEPTH     = 4,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(NOP_WORD)
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       IRWre,
    input  logic [WIDTH-1:0]           in,
    input  logic                       Advance,
    input  logic                       Flush,
    output logic [WIDTH-1:0]           out,
    output logic                       OutValid,
    output logic [$clog2(DEPTH+1)-1:0] Count,
    output logic                       Full,
    output logic                       Empty
`ifdef IR_QUEUE_FIELDS_EN
    ,
    output logic [5:0]                 Op,
    output logic [4:0]                 Rs,
    output logic [4:0]                 Rt,
    output logic [4:0]                 Rd,
    output logic [4:0]                 Shamt,
    output logic [5:0]                 Funct,
    output logic [15:0]                Imm16,
    output logic [25:0]                Addr26
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
        $error("ir_queue: DEPTH must be a power of two and at least 2");
    end

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             pop;
    logic             bypass;
    logic             push;
    logic             mem_we;

    assign Count = count;
    assign Full  = (count == CW'(DEPTH));
    assign Empty = (count == '0);

    // A word arriving while the IR is being advanced over an empty queue skips storage entirely.
    assign pop    = Advance & ~Empty;
    assign bypass = Advance & Empty & IRWre;
    assign push   = IRWre & (~Full | pop) & ~bypass;
    assign mem_we = push & ~Flush;

    ir_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            out      <= RESET_VAL;
            OutValid <= 1'b0;
        end else if (Flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            OutValid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            // The IR only changes value on pop or bypass; a bare Advance just invalidates it.
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out      <= head;
                OutValid <= 1'b1;
            end else if (bypass) begin
                out      <= in;
                OutValid <= 1'b1;
            end else if (Advance) begin
                OutValid <= 1'b0;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef IR_QUEUE_FIELDS_EN
    if (WIDTH != 32) begin : g_width_chk
        $error("ir_queue: IR_QUEUE_FIELDS_EN requires WIDTH == 32");
    end

    assign Op     = out[OP_HI:OP_LO];
    assign Rs     = out[RS_HI:RS_LO];
    assign Rt     = out[RT_HI:RT_LO];
    assign Rd     = out[RD_HI:RD_LO];
    assign Shamt  = out[SHAMT_HI:SHAMT_LO];
    assign Funct  = out[FUNCT_HI:FUNCT_LO];
    assign Imm16  = out[IMM_HI:IMM_LO];
    assign Addr26 = out[ADDR_HI:ADDR_LO];
`endif

endmodule

// File: doc/ir_queue.md
Name: ir_queue

Overview:
- Parametrised instruction register for the multicycle MIPS datapath, with a small prefetch queue in front of the architectural IR.
- Fetch side pushes instruction words with IRWre.
- Control unit retires the current IR word with Advance.
- Flush discards queued words on a branch or jump. The registered `out` feeds the decode and register-file address logic.

Parameters:
- WIDTH, 32: instruction word width in bits.
- DEPTH, 4: prefetch queue entries; a power of two, at least 2.
- RESET_VAL, 0: value of `out` after reset. Default 0 decodes as a MIPS nop.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- IRWre  input  1  push `in` into the queue this cycle.
- in  input  WIDTH  instruction word from instruction memory.
- Advance  input  1  retire the current IR word and load the next one.
- Flush  input  1  discard all queued words and invalidate the IR.
- out  output  WIDTH  current instruction; registered.
- OutValid  output  1  `out` holds a live instruction.
- Count  output  $clog2(DEPTH+1)  number of words queued, excluding `out`.
- Full  output  1  Count == DEPTH.
- Empty  output  1  Count == 0.

Behaviour:
- Reset (Reset == 0, asynchronous):
  - out = RESET_VAL, OutValid = 0, Count = 0, Empty = 1, Full = 0.
  - Read and write pointers return to 0.
  - Reset asserted mid-operation discards all queued words with no further effect.
- Storage: circular buffer of DEPTH entries with log2(DEPTH)-bit pointers that wrap naturally. Full and Empty are decoded from Count, not from pointer comparison.
- Push acceptance:
  - Accepted when IRWre = 1 and (not Full, or a pop occurs in the same cycle).
  - A push into a Full queue with no pop is dropped silently; Count stays at DEPTH.
- Pop: occurs when Advance = 1 and not Empty. Then out <= head entry, OutValid <= 1, and the read pointer increments.
- Bypass: when Advance = 1, Empty = 1 and IRWre = 1, out <= in directly and OutValid <= 1. The word is not written to the queue and Count stays 0. Latency from `in` to `out` is 1 cycle.
- Advance with Empty = 1 and IRWre = 0: OutValid <= 0 and `out` holds its old value. The IR never changes value except on pop, bypass or reset, matching the hold-on-no-write behaviour of the datapath.
- Advance = 0: `out` and OutValid hold; any push only fills the queue.
- Simultaneous push and pop with a non-empty queue: both take effect, Count is unchanged, and `out` takes the old head.
- Flush (highest priority after reset):
  - Count <= 0, pointers <= 0, OutValid <= 0, `out` holds.
  - IRWre and Advance in the same cycle are ignored.
- All outputs are registered or decoded only from registered state. There is no combinational path from inputs to outputs.

Optional Feature:
- Macro: IR_QUEUE_FIELDS_EN.
- When defined, add outputs decoded combinationally from `out`:
  - Op[5:0] = out[31:26]
  - Rs[4:0] = out[25:21]
  - Rt[4:0] = out[20:16]
  - Rd[4:0] = out[15:11]
  - Shamt[4:0] = out[10:6]
  - Funct[5:0] = out[5:0]
  - Imm16[15:0] = out[15:0]
  - Addr26[25:0] = out[25:0]
- These field outputs are only meaningful with WIDTH == 32; an elaboration-time error is raised otherwise.
- When the macro is undefined, these ports do not exist and the only output word is `out`.

Decomposition:
- Shared package `mips_pkg`:
  - field bit-position constants (OP_HI/LO, RS_HI/LO, RT_HI/LO, RD_HI/LO, SHAMT_HI/LO, FUNCT_HI/LO, IMM_HI/LO, ADDR_HI/LO);
  - NOP_WORD = 32'h0.
- One natural sub-module: `ir_fifo_mem`, the DEPTH x WIDTH storage with write port and read address. Pointer, Count and control logic stay in ir_queue.

Test Plan:
- Reset release with RESET_VAL = 0: out = 0, OutValid = 0, Count = 0, Empty = 1; Advance alone -> OutValid stays 0.
- Push 0x20080005, 0x20090003 on consecutive cycles -> Count = 2.
  - Advance -> out = 0x20080005, Count = 1.
  - Advance -> out = 0x20090003, Empty = 1.
- Bypass: Empty, IRWre = 1 with in = 0x01095020 and Advance = 1 -> next cycle out = 0x01095020, OutValid = 1, Count = 0.
- Fill to DEPTH = 4 with words 1..4, then:
  - push 5 without Advance -> dropped, Count = 4, Full = 1;
  - push 5 with Advance -> out = 1, Count = 4, and 5 is later popped after 4;
  - this order exercises pointer wrap.
- Flush with Count = 3, IRWre = 1 and Advance = 1 in the same cycle -> Count = 0, OutValid = 0, `out` unchanged.
- Assert Reset asynchronously between clock edges with Count = 2 -> outputs return to reset values before the next edge. With IR_QUEUE_FIELDS_EN defined and out = 0x8C880004: Op = 0x23, Rs = 4, Rt = 8, Imm16 = 0x0004.
